cp0_int_ctrl: RTL and testbench

- Coprocessor-0 interrupt and exception responder for the pipelined MIPS core.
- Receives the six external hardware interrupt lines (from the bench/bridge devices) and the exception code from the pipeline.
- Decides whether to take an interrupt or exception, holds SR/Cause/EPC/PrID, and services mfc0/mtc0/eret.
- Sits at the M stage; the core flushes and redirects to the handler at 0x0000_4180 when int_req is high.

---
 rtl/cp0_int_ctrl.sv | 133 +++++++++++++
 tb/tb_cp0_int_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_int_ctrl.sv
// CP0 interrupt/exception responder: SR, Cause, EPC, PrID, mfc0/mtc0/eret handling.
// Optional Count/Compare timer on hw_int[5] when CP0_COUNT_EN is defined.
module cp0_int_ctrl #(
    parameter logic [31:0] PRID_VALUE   = 32'h2020_0007,
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  hw_int,
    input  logic [4:0]  exc_code,
    input  logic [31:0] m_pc,
    input  logic        m_bd,
    input  logic        m_valid,
    input  logic [4:0]  cp0_addr,
    input  logic        cp0_we,
    input  logic [31:0] cp0_din,
    input  logic        eret,
    output logic [31:0] cp0_dout,
    output logic        int_req,
    output logic [31:0] epc_out,
    output logic [31:0] handler_pc
);

    localparam logic [4:0] ADDR_COUNT   = 5'd9;
    localparam logic [4:0] ADDR_COMPARE = 5'd11;
    localparam logic [4:0] ADDR_SR      = 5'd12;
    localparam logic [4:0] ADDR_CAUSE   = 5'd13;
    localparam logic [4:0] ADDR_EPC     = 5'd14;
    localparam logic [4:0] ADDR_PRID    = 5'd15;

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;

    logic [5:0]  hw_eff;
    logic        irq;
    logic        exc;
    logic [31:0] epc_next;
    logic        mtc0_ok;

`ifdef CP0_COUNT_EN
    logic [31:0] count;
    logic [31:0] compare;
    logic        timer_q;
    logic        timer_hit;

    assign timer_hit = (count == compare) && (compare != 32'd0);

    // Timer request stays latched until software rewrites Compare.
    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= 32'd0;
            compare <= 32'd0;
            timer_q <= 1'b0;
        end else begin
            if (mtc0_ok && cp0_addr == ADDR_COUNT)
                count <= cp0_din;
            else
                count <= count + 32'd1;
            if (mtc0_ok && cp0_addr == ADDR_COMPARE) begin
                compare <= cp0_din;
                timer_q <= 1'b0;
            end else begin
                timer_q <= timer_q | timer_hit;
            end
        end
    end

    assign hw_eff = {hw_int[5] | timer_hit | timer_q, hw_int[4:0]};
`else
    assign hw_eff = hw_int;
`endif

    assign irq      = sr_ie && !sr_exl && ((hw_eff & sr_im) != 6'd0);
    assign exc      = (exc_code != 5'd0) && !sr_exl && m_valid;
    assign int_req  = irq | exc;
    assign mtc0_ok  = cp0_we && !int_req;
    assign epc_next = m_bd ? (m_pc - 32'd4) : m_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im     <= 6'd0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= 6'd0;
            cause_exc <= 5'd0;
            epc       <= 32'd0;
        end else begin
            cause_ip <= hw_eff;
            if (int_req) begin
                sr_exl    <= 1'b1;
                cause_exc <= irq ? 5'd0 : exc_code;
                cause_bd  <= m_bd;
                epc       <= epc_next & 32'hFFFF_FFFC;
            end else begin
                if (mtc0_ok && cp0_addr == ADDR_SR) begin
                    sr_im  <= cp0_din[15:10];
                    sr_exl <= cp0_din[1];
                    sr_ie  <= cp0_din[0];
                end
                if (mtc0_ok && cp0_addr == ADDR_EPC)
                    epc <= cp0_din & 32'hFFFF_FFFC;
                // eret's EXL clear overrides a coincident SR write.
                if (eret)
                    sr_exl <= 1'b0;
            end
        end
    end

    always_comb begin
        cp0_dout = 32'd0;
        case (cp0_addr)
            ADDR_SR:    cp0_dout = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
            ADDR_CAUSE: cp0_dout = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'd0};
            ADDR_EPC:   cp0_dout = epc;
            ADDR_PRID:  cp0_dout = PRID_VALUE;
`ifdef CP0_COUNT_EN
            ADDR_COUNT:   cp0_dout = count;
            ADDR_COMPARE: cp0_dout = compare;
`endif
            default:    cp0_dout = 32'd0;
        endcase
    end

    assign epc_out    = epc;
    assign handler_pc = HANDLER_ADDR;

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Bench for cp0_int_ctrl: directed scenarios plus randomized traffic against a register-level model.
module tb_cp0_int_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  hw_int;
    logic [4:0]  exc_code;
    logic [31:0] m_pc;
    logic        m_bd;
    logic        m_valid;
    logic [4:0]  cp0_addr;
    logic        cp0_we;
    logic [31:0] cp0_din;
    logic        eret;
    logic [31:0] cp0_dout;
    logic        int_req;
    logic [31:0] epc_out;
    logic [31:0] handler_pc;

    int vecs = 0;
    int errs = 0;

    // Architectural model state
    logic [5:0]  md_im, md_ip;
    logic        md_exl, md_ie, md_bd;
    logic [4:0]  md_code;
    logic [31:0] md_epc;

    cp0_int_ctrl dut (
        .clk(clk), .reset(reset), .hw_int(hw_int), .exc_code(exc_code),
        .m_pc(m_pc), .m_bd(m_bd), .m_valid(m_valid), .cp0_addr(cp0_addr),
        .cp0_we(cp0_we), .cp0_din(cp0_din), .eret(eret), .cp0_dout(cp0_dout),
        .int_req(int_req), .epc_out(epc_out), .handler_pc(handler_pc)
    );

    always #5 clk = ~clk;

    function automatic logic md_irq();
        return md_ie && !md_exl && ((hw_int & md_im) != 6'd0);
    endfunction

    function automatic logic md_exc();
        return (exc_code != 5'd0) && !md_exl && m_valid;
    endfunction

    function automatic logic [31:0] md_read(input logic [4:0] a);
        case (a)
            5'd12:   return (32'(md_im) << 10) | (32'(md_exl) << 1) | 32'(md_ie);
            5'd13:   return (32'(md_bd) << 31) | (32'(md_ip) << 10) | (32'(md_code) << 2);
            5'd14:   return md_epc;
            5'd15:   return 32'h2020_0007;
            default: return 32'd0;
        endcase
    endfunction

    task automatic set_idle();
        reset = 1'b0; hw_int = 6'd0; exc_code = 5'd0; m_pc = 32'd0; m_bd = 1'b0;
        m_valid = 1'b0; cp0_addr = 5'd0; cp0_we = 1'b0; cp0_din = 32'd0; eret = 1'b0;
    endtask

    // Advance one clock, stepping the model with the inputs present at the edge.
    task automatic cycle();
        logic ir, take;
        logic [5:0] n_im, n_ip; logic n_exl, n_ie, n_bd; logic [4:0] n_code; logic [31:0] n_epc;
        ir = md_irq();
        take = ir || md_exc();
        n_im = md_im; n_ip = md_ip; n_exl = md_exl; n_ie = md_ie; n_bd = md_bd;
        n_code = md_code; n_epc = md_epc;
        if (reset) begin
            n_im = 0; n_ip = 0; n_exl = 0; n_ie = 0; n_bd = 0; n_code = 0; n_epc = 0;
        end else begin
            n_ip = hw_int;
            if (take) begin
                n_exl = 1'b1;
                n_code = ir ? 5'd0 : exc_code;
                n_bd = m_bd;
                n_epc = (m_bd ? m_pc - 32'd4 : m_pc) & ~32'd3;
            end else begin
                if (cp0_we && cp0_addr == 5'd12) begin
                    n_im = cp0_din[15:10]; n_exl = cp0_din[1]; n_ie = cp0_din[0];
                end
                if (cp0_we && cp0_addr == 5'd14) n_epc = cp0_din & ~32'd3;
                if (eret) n_exl = 1'b0;
            end
        end
        @(posedge clk);
        md_im = n_im; md_ip = n_ip; md_exl = n_exl; md_ie = n_ie; md_bd = n_bd;
        md_code = n_code; md_epc = n_epc;
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1'b1; hw_int = 6'h3F;
        repeat (3) cycle();
        cp0_addr = 5'd12; #1; vecs++;
        if (cp0_dout !== 32'd0) begin errs++; $display("FAIL reset_sr: got %h want 0", cp0_dout); end
        cp0_addr = 5'd13; #1; vecs++;
        if (cp0_dout !== 32'd0) begin errs++; $display("FAIL reset_cause: got %h want 0", cp0_dout); end
        cp0_addr = 5'd14; #1; vecs++;
        if (cp0_dout !== 32'd0) begin errs++; $display("FAIL reset_epc: got %h want 0", cp0_dout); end
        vecs++;
        if (int_req !== 1'b0) begin errs++; $display("FAIL reset_int_req: got %b want 0", int_req); end
        reset = 1'b0;
        cycle();
        cp0_addr = 5'd13; #1; vecs++;
        if (cp0_dout !== 32'h0000_FC00) begin errs++; $display("FAIL reset_ip: got %h want 0000fc00", cp0_dout); end
        vecs++;
        if (int_req !== 1'b0) begin errs++; $display("FAIL reset_ie_off: got %b want 0", int_req); end
        set_idle();
        cycle();
    endtask

    task automatic test_interrupt();
        set_idle();
        cp0_we = 1'b1; cp0_addr = 5'd12; cp0_din = 32'h0000_0401;
        cycle();
        set_idle();
        hw_int = 6'h01; m_pc = 32'h0000_3024; m_valid = 1'b1; #1; vecs++;
        if (int_req !== 1'b1) begin errs++; $display("FAIL irq_take: got %b want 1", int_req); end
        cycle();
        vecs++;
        if (int_req !== 1'b0) begin errs++; $display("FAIL irq_exl_mask: got %b want 0", int_req); end
        vecs++;
        if (epc_out !== 32'h0000_3024) begin errs++; $display("FAIL irq_epc: got %h want 00003024", epc_out); end
        cp0_addr = 5'd12; #1; vecs++;
        if (cp0_dout !== 32'h0000_0403) begin errs++; $display("FAIL irq_sr: got %h want 00000403", cp0_dout); end
        cp0_addr = 5'd13; #1; vecs++;
        if (cp0_dout !== 32'h0000_0400) begin errs++; $display("FAIL irq_cause: got %h want 00000400", cp0_dout); end
        set_idle(); eret = 1'b1;
        cycle();
        set_idle();
    endtask

    task automatic test_delay_slot();
        set_idle();
        exc_code = 5'd4; m_bd = 1'b1; m_pc = 32'h0000_3010; m_valid = 1'b1; #1; vecs++;
        if (int_req !== 1'b1) begin errs++; $display("FAIL bd_take: got %b want 1", int_req); end
        cycle();
        set_idle();
        cp0_addr = 5'd14; #1; vecs++;
        if (cp0_dout !== 32'h0000_300C) begin errs++; $display("FAIL bd_epc: got %h want 0000300c", cp0_dout); end
        cp0_addr = 5'd13; #1; vecs++;
        if (cp0_dout !== 32'h8000_0010) begin errs++; $display("FAIL bd_cause: got %h want 80000010", cp0_dout); end
        eret = 1'b1; cycle(); set_idle();
        // Delay-slot PC near zero: subtraction wraps
        exc_code = 5'd8; m_bd = 1'b1; m_pc = 32'h0000_0002; m_valid = 1'b1;
        cycle();
        set_idle(); #1; vecs++;
        if (epc_out !== 32'hFFFF_FFFC) begin errs++; $display("FAIL bd_wrap: got %h want fffffffc", epc_out); end
        eret = 1'b1; cycle(); set_idle();
    endtask

    task automatic test_simultaneous();
        set_idle();
        hw_int = 6'h01; exc_code = 5'd10; m_valid = 1'b1; m_pc = 32'h0000_4000;
        cp0_we = 1'b1; cp0_addr = 5'd14; cp0_din = 32'h0000_1234; #1; vecs++;
        if (int_req !== 1'b1) begin errs++; $display("FAIL sim_take: got %b want 1", int_req); end
        cycle();
        set_idle();
        cp0_addr = 5'd14; #1; vecs++;
        if (cp0_dout !== 32'h0000_4000) begin errs++; $display("FAIL sim_epc: got %h want 00004000", cp0_dout); end
        cp0_addr = 5'd13; #1; vecs++;
        if (cp0_dout !== 32'h0000_0400) begin errs++; $display("FAIL sim_cause: got %h want 00000400", cp0_dout); end
        eret = 1'b1; cycle(); set_idle();
    endtask

    task automatic test_masking();
        set_idle();
        cp0_we = 1'b1; cp0_addr = 5'd12; cp0_din = 32'h0000_1003;
        cycle();
        set_idle();
        hw_int = 6'h04; exc_code = 5'd12; m_valid = 1'b1; #1; vecs++;
        if (int_req !== 1'b0) begin errs++; $display("FAIL mask_exl: got %b want 0", int_req); end
        cycle();
        vecs++;
        if (int_req !== 1'b0) begin errs++; $display("FAIL mask_hold: got %b want 0", int_req); end
        exc_code = 5'd0; m_valid = 1'b0; eret = 1'b1; #1; vecs++;
        if (int_req !== 1'b0) begin errs++; $display("FAIL mask_eret_cycle: got %b want 0", int_req); end
        cycle();
        eret = 1'b0; #1; vecs++;
        if (int_req !== 1'b1) begin errs++; $display("FAIL mask_after_eret: got %b want 1", int_req); end
        set_idle();
        cycle();
        // eret and an SR write setting EXL in the same cycle: EXL ends cleared
        cp0_we = 1'b1; cp0_addr = 5'd12; cp0_din = 32'h0000_0003; eret = 1'b1;
        cycle();
        set_idle(); cp0_addr = 5'd12; #1; vecs++;
        if (cp0_dout !== 32'h0000_0001) begin errs++; $display("FAIL eret_vs_mtc0: got %h want 00000001", cp0_dout); end
        cycle();
    endtask

    task automatic test_misc_regs();
        set_idle();
`ifndef CP0_COUNT_EN
        cp0_we = 1'b1; cp0_addr = 5'd9; cp0_din = 32'h0000_0005; cycle();
        cp0_addr = 5'd11; cp0_din = 32'h0000_0007; cycle();
        set_idle();
        cp0_addr = 5'd9; #1; vecs++;
        if (cp0_dout !== 32'd0) begin errs++; $display("FAIL count_absent: got %h want 0", cp0_dout); end
        cp0_addr = 5'd11; #1; vecs++;
        if (cp0_dout !== 32'd0) begin errs++; $display("FAIL compare_absent: got %h want 0", cp0_dout); end
`endif
        cp0_we = 1'b1; cp0_addr = 5'd13; cp0_din = 32'hFFFF_FFFF; cycle();
        cp0_addr = 5'd15; cycle();
        set_idle();
        cp0_addr = 5'd13; #1; vecs++;
        if (cp0_dout !== 32'd0) begin errs++; $display("FAIL cause_ro: got %h want 0", cp0_dout); end
        cp0_addr = 5'd15; #1; vecs++;
        if (cp0_dout !== 32'h2020_0007) begin errs++; $display("FAIL prid: got %h want 20200007", cp0_dout); end
        vecs++;
        if (handler_pc !== 32'h0000_4180) begin errs++; $display("FAIL handler_pc: got %h want 00004180", handler_pc); end
    endtask

    task automatic test_random();
        logic [31:0] exp_d;
        logic exp_r;
        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom_range(0, 49) == 0);
            hw_int   = ($urandom_range(0, 2) == 0) ? 6'($urandom()) : 6'd0;
            exc_code = ($urandom_range(0, 3) == 0) ? 5'($urandom()) : 5'd0;
            m_pc     = $urandom();
            m_bd     = 1'($urandom());
            m_valid  = 1'($urandom());
            cp0_addr = 5'($urandom_range(8, 16));
            if (cp0_addr == 5'd9 || cp0_addr == 5'd11) cp0_addr = 5'd12;
            cp0_we   = ($urandom_range(0, 2) == 0);
            cp0_din  = $urandom();
            eret     = ($urandom_range(0, 5) == 0);
            #1;
            exp_r = md_irq() || md_exc();
            exp_d = md_read(cp0_addr);
            vecs++;
            if (int_req !== exp_r) begin
                errs++; $display("FAIL rnd_int_req[%0d]: got %b want %b", i, int_req, exp_r);
            end
            vecs++;
            if (cp0_dout !== exp_d) begin
                errs++; $display("FAIL rnd_dout[%0d] addr %0d: got %h want %h", i, cp0_addr, cp0_dout, exp_d);
            end
            vecs++;
            if (epc_out !== md_epc) begin
                errs++; $display("FAIL rnd_epc_out[%0d]: got %h want %h", i, epc_out, md_epc);
            end
            cycle();
        end
        set_idle();
    endtask

    initial begin
        md_im = 0; md_ip = 0; md_exl = 0; md_ie = 0; md_bd = 0; md_code = 0; md_epc = 0;
        set_idle();
        test_reset();
        test_interrupt();
        test_delay_slot();
        test_simultaneous();
        test_masking();
        test_misc_regs();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
